// File: rtl/fir_out_sink.sv
// Output-side receiver for fir_alu: captures the FP16 result once per sample frame,
// converts it to saturated signed fixed point and queues it in a first-word-fall-through FIFO.
module fir_out_sink #(
  parameter int FRAME_LEN   = 65,
  parameter int CAPTURE_OFS = 64,
  parameter int FRAC_BITS   = 15,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [15:0]              y_float,
  output logic                     sample_strobe,
  output logic [15:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAPTURE_OFS);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  function automatic logic signed [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)       return 16'sh7FFF;
    else if (v < -64'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  // Magnitude is truncated by the right shift before the sign is applied,
  // so negative results round toward zero as well.
  function automatic logic signed [15:0] fp16_to_fix(input logic [15:0] f);
    logic [4:0]         e;
    logic [9:0]         m;
    logic [63:0]        mant;
    logic [63:0]        mag;
    logic signed [63:0] val;
    int                 sh;
    e = f[14:10];
    m = f[9:0];
    if (e == 5'd31) return (m != 10'd0) ? 16'sh0000 : (f[15] ? 16'sh8000 : 16'sh7FFF);
    if (e == 5'd0) begin
      mant = {54'd0, m};
      sh   = FRAC_BITS - 24;
    end else begin
      mant = {53'd0, 1'b1, m};
      sh   = int'(e) - 25 + FRAC_BITS;
    end
    if (sh > 40) sh = 40;
    if (sh >= 0) mag = mant << sh;
    else         mag = mant >> (-sh);
    val = f[15] ? -$signed(mag) : $signed(mag);
    return sat16(val);
  endfunction

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               vld_p0_q, vld_p1_q;
  logic [15:0]        cap_p0_q;
  logic signed [15:0] dec_p1_q;
  logic signed [15:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic signed [15:0] hold_q, hold_d;
  logic               full, pop, push_ok;

  assign sample_strobe = (cnt_q == CNT_CAP) && en;
  assign cnt_d = en ? ((cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1)) : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      vld_p0_q <= sample_strobe;
      vld_p1_q <= vld_p0_q;
    end
  end

  // p0: capture register; p1: decoded fixed-point word
  always_ff @(posedge clk) begin
    if (sample_strobe) cap_p0_q <= y_float;
    if (vld_p0_q)      dec_p1_q <= fp16_to_fix(cap_p0_q);
  end

  // FIFO write/read stage
  assign full    = (level_q == LVL_FULL);
  assign pop     = out_valid && out_ready;
  assign push_ok = vld_p1_q && (!full || pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    hold_d  = hold_q;
    if (push_ok) wr_d = wr_q + PTR_W'(1);
    if (pop) begin
      rd_d   = rd_q + PTR_W'(1);
      hold_d = mem[rd_q];
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (vld_p1_q && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= dec_p1_q;
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem[rd_q] : hold_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule
